// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline port P has priority, debug port D gets
// a bounded-wait guarantee. Commands are registered; read data returns to the owner.
module dmem_arbiter #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  output logic              m_re,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              err_clr,
  output logic              err_addr
);

  localparam logic [3:0]        MaxWait = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] DepthA  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, OWN_P, OWN_D} owner_e;

  owner_e            owner_q, owner_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_we_q, m_we_d, m_re_q, m_re_d;
  logic              rd_q, rd_d, zero_q, zero_d;
  logic              err_q, err_d;
  logic              p_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] p_rdata_q, d_rdata_q;

  logic              force_w, d_win, p_win, any_win, win_we, oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign force_w   = d_req && (wait_cnt_q == MaxWait);
  assign d_win     = force_w || (!p_req && d_req);
  assign p_win     = p_req && !force_w;
  assign any_win   = d_win || p_win;
  assign win_addr  = d_win ? d_addr  : p_addr;
  assign win_wdata = d_win ? d_wdata : p_wdata;
  assign win_we    = d_win ? d_we    : p_we;
  assign oor       = any_win && (win_addr >= DepthA);

  // Handshake outputs are held low while reset is asserted.
  assign p_stall = rst_n && force_w && p_req;
  assign d_gnt   = rst_n && d_win;

  always_comb begin
    wait_cnt_d = '0;
    owner_d    = IDLE;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_we_d     = 1'b0;
    m_re_d     = 1'b0;
    rd_d       = 1'b0;
    zero_d     = 1'b0;
    err_d      = err_q;

    if (d_req && !d_win)
      wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 4'd1;

    if (any_win) begin
      owner_d   = d_win ? OWN_D : OWN_P;
      m_addr_d  = win_addr;
      m_wdata_d = win_wdata;
      m_we_d    = win_we && !oor;
      m_re_d    = !win_we && !oor;
      rd_d      = !win_we;
      zero_d    = oor;
    end

    if (oor)
      err_d = 1'b1;
    else if (err_clr)
      err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= IDLE;
      wait_cnt_q <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_we_q     <= 1'b0;
      m_re_q     <= 1'b0;
      rd_q       <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      p_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_we_q     <= m_we_d;
      m_re_q     <= m_re_d;
      rd_q       <= rd_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
      p_rvalid_q <= (owner_q == OWN_P) && rd_q;
      d_rvalid_q <= (owner_q == OWN_D) && rd_q;
      // Out-of-range reads never reached memory, so they return zero.
      if ((owner_q == OWN_P) && rd_q) p_rdata_q <= zero_q ? '0 : m_rdata;
      if ((owner_q == OWN_D) && rd_q) d_rdata_q <= zero_q ? '0 : m_rdata;
    end
  end

  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_we     = m_we_q;
  assign m_re     = m_re_q;
  assign err_addr = err_q;
  assign p_rvalid = p_rvalid_q;
  assign p_rdata  = p_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 64;

  logic        clk, rst_n;
  logic        p_req, p_we, p_stall, p_rvalid;
  logic [15:0] p_addr, p_wdata, p_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [15:0] m_addr, m_wdata, m_rdata;
  logic        m_we, m_re, err_clr, err_addr;

  int tests = 0;
  int fails = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata),
    .err_clr(err_clr), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory acting on the falling edge.
  logic [15:0] phys [0:DEPTH-1];
  always @(negedge clk) begin
    if (m_we) phys[m_addr[5:0]] <= m_wdata;
    if (m_re) m_rdata <= phys[m_addr[5:0]];
  end

  // Reference model: memory image updated in acceptance order, pending read return.
  logic [15:0] ref_mem [0:DEPTH-1];
  int          wcnt;
  logic        st_v, st_isp;
  logic [15:0] st_data;
  logic        e_prv, e_drv, e_mwe, e_mre, e_err, e_stall, e_gnt;
  logic [15:0] e_prd, e_drd, e_maddr;

  task automatic model_reset();
    wcnt = 0; st_v = 1'b0; st_isp = 1'b0; st_data = '0;
    e_prv = 1'b0; e_drv = 1'b0; e_prd = '0; e_drd = '0;
    e_mwe = 1'b0; e_mre = 1'b0; e_maddr = '0; e_err = 1'b0;
  endtask

  task automatic drive(input logic pr, input logic pw, input logic [15:0] pa, input logic [15:0] pd,
                       input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                       input logic ec);
    logic frc;
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; err_clr = ec;
    #3;
    frc     = dr && (wcnt == int'(MAX_WAIT));
    e_gnt   = frc || (!pr && dr);
    e_stall = frc && pr;
  endtask

  task automatic advance();
    logic        dwin, pwin, we, out;
    logic [15:0] a, wd;
    @(posedge clk); #1;
    dwin = e_gnt;
    pwin = p_req && !e_gnt;
    e_prv = st_v && st_isp;
    e_drv = st_v && !st_isp;
    if (e_prv) e_prd = st_data;
    if (e_drv) e_drd = st_data;
    st_v = 1'b0; e_mwe = 1'b0; e_mre = 1'b0; out = 1'b0;
    if (dwin || pwin) begin
      a  = dwin ? d_addr : p_addr;
      wd = dwin ? d_wdata : p_wdata;
      we = dwin ? d_we : p_we;
      out = (int'(a) >= int'(DEPTH));
      e_maddr = a;
      e_mwe = we && !out;
      e_mre = !we && !out;
      if (!we) begin
        st_v = 1'b1; st_isp = pwin;
        st_data = out ? 16'h0 : ref_mem[a[5:0]];
      end else if (!out) begin
        ref_mem[a[5:0]] = wd;
      end
    end
    if (out) e_err = 1'b1;
    else if (err_clr) e_err = 1'b0;
    if (d_req && !dwin) wcnt = (wcnt < int'(MAX_WAIT)) ? wcnt + 1 : wcnt;
    else wcnt = 0;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 0, 16'h5, 16'h0, 1, 1, 16'h9, 16'h1, 0);
    tests++;
    if ({p_stall, d_gnt, p_rvalid, d_rvalid, m_we, m_re, err_addr} !== 7'b0 ||
        p_rdata !== 16'h0 || d_rdata !== 16'h0 || m_addr !== 16'h0 || m_wdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ctl=%b p_rdata=%h m_addr=%h want all zero",
               {p_stall, d_gnt, p_rvalid, d_rvalid, m_we, m_re, err_addr}, p_rdata, m_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_p_read();
    drive(1, 0, 16'd5, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    tests++;
    if (p_stall !== 1'b0) begin fails++; $display("FAIL p_read_stall: got %b want 0", p_stall); end
    advance(); idle();
    tests++;
    if (m_re !== 1'b1 || m_we !== 1'b0 || m_addr !== 16'd5) begin
      fails++; $display("FAIL p_read_issue: got re=%b we=%b addr=%h want re=1 we=0 addr=0005", m_re, m_we, m_addr);
    end
    advance(); idle();
    tests++;
    if (p_rvalid !== 1'b1 || p_rdata !== 16'd7) begin
      fails++; $display("FAIL p_read_data: got rvalid=%b rdata=%h want 1/0007", p_rvalid, p_rdata);
    end
    advance(); idle();
    tests++;
    if (p_rvalid !== 1'b0) begin fails++; $display("FAIL p_read_pulse: got rvalid=%b want 0", p_rvalid); end
    advance();
  endtask

  task automatic test_d_write_read();
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'd9, 16'h00AB, 0);
    tests++;
    if (d_gnt !== 1'b1) begin fails++; $display("FAIL d_write_gnt: got %b want 1", d_gnt); end
    advance();
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'd9, 16'h0, 0);
    tests++;
    if (m_we !== 1'b1 || m_addr !== 16'd9 || m_wdata !== 16'h00AB || d_gnt !== 1'b1) begin
      fails++; $display("FAIL d_write_issue: got we=%b addr=%h wdata=%h gnt=%b want 1/0009/00ab/1",
                        m_we, m_addr, m_wdata, d_gnt);
    end
    advance(); idle();
    tests++;
    if (d_rvalid !== 1'b0) begin fails++; $display("FAIL d_read_early: got rvalid=%b want 0", d_rvalid); end
    advance(); idle();
    tests++;
    if (d_rvalid !== 1'b1 || d_rdata !== 16'h00AB) begin
      fails++; $display("FAIL d_read_data: got rvalid=%b rdata=%h want 1/00ab", d_rvalid, d_rdata);
    end
    advance();
  endtask

  task automatic test_starvation();
    logic dr;
    idle(); advance();
    dr = 1'b1;
    for (int c = 0; c < 9; c++) begin
      drive(1, 0, 16'd6, 16'h0, dr, 0, 16'd7, 16'h0, 0);
      tests++;
      if (d_gnt !== (c == 4) || p_stall !== (c == 4)) begin
        fails++; $display("FAIL starvation_c%0d: got gnt=%b stall=%b want %b/%b", c, d_gnt, p_stall, c == 4, c == 4);
      end
      if (d_gnt) dr = 1'b0;
      advance();
    end
    idle(); advance(); idle(); advance();
  endtask

  task automatic test_out_of_range();
    drive(1, 0, 16'd64, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    tests++;
    if (p_stall !== 1'b0) begin fails++; $display("FAIL oor_stall: got %b want 0", p_stall); end
    advance(); idle();
    tests++;
    if (m_re !== 1'b0 || m_we !== 1'b0 || err_addr !== 1'b1) begin
      fails++; $display("FAIL oor_issue: got re=%b we=%b err=%b want 0/0/1", m_re, m_we, err_addr);
    end
    advance();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    tests++;
    if (p_rvalid !== 1'b1 || p_rdata !== 16'h0) begin
      fails++; $display("FAIL oor_rdata: got rvalid=%b rdata=%h want 1/0000", p_rvalid, p_rdata);
    end
    advance();
    drive(1, 0, 16'h8005, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    tests++;
    if (err_addr !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", err_addr); end
    advance(); idle();
    tests++;
    if (err_addr !== 1'b1 || m_re !== 1'b0) begin
      fails++; $display("FAIL err_set_wins: got err=%b re=%b want 1/0", err_addr, m_re);
    end
    advance(); idle(); advance();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 1); advance();
  endtask

  task automatic test_reset_mid_read();
    drive(1, 0, 16'd6, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    advance(); idle();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({p_stall, d_gnt, p_rvalid, d_rvalid, m_we, m_re, err_addr} !== 7'b0 || p_rdata !== 16'h0 || m_addr !== 16'h0) begin
      fails++; $display("FAIL reset_mid_outputs: got ctl=%b p_rdata=%h m_addr=%h want zero",
                        {p_stall, d_gnt, p_rvalid, d_rvalid, m_we, m_re, err_addr}, p_rdata, m_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      tests++;
      if (p_rvalid !== 1'b0) begin fails++; $display("FAIL reset_no_rvalid_c%0d: got %b want 0", c, p_rvalid); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want [3];
    want[0] = 16'd7; want[1] = 16'd4; want[2] = 16'd4;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1, 0, 16'(5 + c), 16'h0, 0, 0, 16'h0, 16'h0, 0);
      else idle();
      if (c >= 2) begin
        tests++;
        if (p_rvalid !== 1'b1 || p_rdata !== want[c-2]) begin
          fails++; $display("FAIL b2b_read%0d: got rvalid=%b rdata=%h want 1/%h", c - 2, p_rvalid, p_rdata, want[c-2]);
        end
      end
      advance();
    end
    idle();
    tests++;
    if (p_rvalid !== 1'b0) begin fails++; $display("FAIL b2b_end: got rvalid=%b want 0", p_rvalid); end
    advance();
  endtask

  task automatic test_random();
    logic        dhold, dw, pr, pw, dr, ec;
    logic [15:0] da, dd, pa;
    dhold = 1'b0; dw = 1'b0; da = '0; dd = '0;
    for (int c = 0; c < 400; c++) begin
      pr = ($urandom_range(0, 9) < 6);
      pw = $urandom_range(0, 1) == 1;
      pa = ($urandom_range(0, 15) == 0) ? 16'hFF00 | 16'($urandom_range(0, 63)) : 16'($urandom_range(0, 71));
      if (!dhold) begin
        dr = ($urandom_range(0, 2) == 0);
        dw = $urandom_range(0, 1) == 1;
        da = 16'($urandom_range(0, 70));
        dd = 16'($urandom);
      end
      ec = ($urandom_range(0, 7) == 0);
      drive(pr, pw, pa, 16'($urandom), dr, dw, da, dd, ec);
      dhold = dr && !e_gnt;
      tests++;
      if (p_stall !== e_stall || d_gnt !== e_gnt) begin
        fails++; $display("FAIL rnd_arb_c%0d: got stall=%b gnt=%b want %b/%b", c, p_stall, d_gnt, e_stall, e_gnt);
      end
      tests++;
      if (p_rvalid !== e_prv || p_rdata !== e_prd || d_rvalid !== e_drv || d_rdata !== e_drd) begin
        fails++; $display("FAIL rnd_rdata_c%0d: got p=%b/%h d=%b/%h want p=%b/%h d=%b/%h",
                          c, p_rvalid, p_rdata, d_rvalid, d_rdata, e_prv, e_prd, e_drv, e_drd);
      end
      tests++;
      if (m_we !== e_mwe || m_re !== e_mre || ((e_mwe || e_mre) && m_addr !== e_maddr) || err_addr !== e_err) begin
        fails++; $display("FAIL rnd_issue_c%0d: got we=%b re=%b addr=%h err=%b want %b/%b/%h/%b",
                          c, m_we, m_re, m_addr, err_addr, e_mwe, e_mre, e_maddr, e_err);
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) phys[i] = 16'($urandom);
    phys[5] = 16'd7; phys[6] = 16'd4; phys[7] = 16'd4;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = phys[i];
    model_reset();
    test_reset();
    test_p_read();
    test_d_write_read();
    test_starvation();
    test_out_of_range();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters:
  - the pipeline MEM stage (port P, normally highest priority);
  - a debug/loader port (port D, valid/grant handshake).
- Registers one memory command per cycle and routes the returned read data to the owning requester.
- Guarantees D cannot starve, via a bounded-wait counter that stalls the pipeline for one slot.
- Flags out-of-range addresses.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width of both ports and of the memory
- DEPTH, 64, number of implemented memory words; addresses >= DEPTH are out of range
- MAX_WAIT, 4, max consecutive cycles D may be refused before it is forced through; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p_req  in  1  pipeline access valid (MemRead|MemWrite)
- p_we  in  1  pipeline write (1) / read (0)
- p_addr  in  ADDR_W  pipeline word address
- p_wdata  in  DATA_W  pipeline store data
- p_stall  out  1  combinational; pipeline must hold MEM stage this cycle
- p_rvalid  out  1  pipeline read data valid
- p_rdata  out  DATA_W  pipeline read data
- d_req  in  1  debug access valid; held until d_gnt
- d_we  in  1  debug write/read
- d_addr  in  ADDR_W  debug address
- d_wdata  in  DATA_W  debug store data
- d_gnt  out  1  combinational; request accepted this cycle
- d_rvalid  out  1  debug read data valid
- d_rdata  out  DATA_W  debug read data
- m_addr  out  ADDR_W  registered memory address
- m_wdata  out  DATA_W  registered memory write data
- m_we  out  1  registered memory write enable
- m_re  out  1  registered memory read enable
- m_rdata  in  DATA_W  memory read data, valid before the next rising edge after m_* issue (memory acts on falling edge)
- err_clr  in  1  clears err_addr
- err_addr  out  1  sticky out-of-range flag

Behaviour:
- Reset (rst_n low, async): all outputs 0, wait_cnt=0, owner=IDLE. Reset mid-operation drops any in-flight read; no rvalid is produced after release.
- Arbitration, evaluated each cycle (cycle N):
  - force = d_req && wait_cnt==MAX_WAIT.
  - If force: D wins; p_stall = p_req.
  - Else if p_req: P wins; p_stall=0.
  - Else if d_req: D wins.
  - p_stall is never asserted when p_req=0.
- d_gnt=1 exactly in the cycles D wins.
- wait_cnt:
  - increments (saturating at MAX_WAIT) when d_req && !d_gnt;
  - resets to 0 on d_gnt, or when d_req=0.
- Issue: at the rising edge ending cycle N, the winner's addr/wdata go to m_addr/m_wdata, with m_we=winner_we, m_re=!winner_we. With no winner, m_we=m_re=0 and owner=IDLE.
- Owner FSM: IDLE / OWN_P / OWN_D, registered with m_*. It records which requester the issued command (cycle N+1) belongs to.
- Read return:
  - at the rising edge ending N+1, if owner is P/D and the command was a read, m_rdata is captured into p_rdata/d_rdata and the matching rvalid is set for cycle N+2;
  - rvalid is a 1-cycle pulse;
  - rdata holds its last value otherwise.
  - Read latency: 2 cycles from acceptance.
  - Back-to-back accepts sustain 1 access/cycle.
- Writes produce no rvalid.
- Out-of-range (winner addr >= DEPTH):
  - the handshake completes normally (stall/gnt as above);
  - m_we=m_re=0 for that slot;
  - a read still returns rvalid with rdata=0;
  - err_addr set at that edge.
- err_clr clears err_addr; a simultaneous set wins.
- Address compare uses full ADDR_W bits; no wrap-around or truncation.
- Simultaneous P and D to the same address: strict issue order applies. A read issued after a write sees the written data.

Test Plan:
- P-only read: p_req=1, p_we=0, p_addr=5, memory holds 7 at addr 5 -> m_re=1 and m_addr=5 in cycle 1; p_rvalid=1, p_rdata=7 in cycle 2; p_stall stays 0.
- D write/read with P idle: d_req=1, d_we=1, d_addr=9, d_wdata=0x00AB -> d_gnt same cycle, m_we=1 next cycle. A following D read of addr 9 -> d_rvalid pulse with d_rdata=0x00AB two cycles after its grant.
- Starvation bound: p_req held 1 and d_req held 1 from cycle 0, MAX_WAIT=4 -> d_gnt=1 and p_stall=1 in cycle 4 only. P is granted in cycles 0-3 and from cycle 5 on; wait_cnt=0 after the grant.
- Out-of-range: p_addr=64, read -> m_re=0, p_rvalid=1 with p_rdata=0, err_addr=1. err_clr=1 alone -> err_addr=0. err_clr=1 together with a new out-of-range access -> err_addr stays 1.
- Reset mid-read: P read accepted in cycle 0, rst_n low in cycle 1 -> all outputs 0; no p_rvalid after release; owner=IDLE.
- Back-to-back P reads of addrs 5, 6, 7 (values 7, 4, 4) -> p_rvalid high for 3 consecutive cycles with p_rdata 7, 4, 4.
